fx_addsub_pipe: RTL
===================

FX_ADDSUB_PIPE -- requirements
Module: fx_addsub_pipe

Interface
REQ-001 Parameter IN1_W, default 12, total width of signed operand 1.
REQ-002 Parameter IN1_FRAC, default 8, fractional bits of operand 1.
REQ-003 Parameter IN2_W, default 12, total width of signed operand 2.
REQ-004 Parameter IN2_FRAC, default 8, fractional bits of operand 2.
REQ-005 Parameter OUT_W, default 12, total width of signed result.
REQ-006 Parameter OUT_FRAC, default 8, fractional bits of result.
REQ-007 Parameter LATENCY, default 2, input-to-output register count, legal range 1..16.
REQ-008 Parameter SAT_EN, default 1: 1 saturates on overflow, 0 wraps.
REQ-009 Parameter RND_EN, default 0: 1 rounds half-up, 0 truncates toward minus infinity.
REQ-010 Parameter CNT_W, default 16, overflow counter width.
REQ-011 One clock; reset is asynchronous and active-high.
REQ-012 i_clk  in  1  rising-edge clock.
REQ-013 i_rst  in  1  asynchronous active-high reset.
REQ-014 i_valid  in  1  input sample qualifier.
REQ-015 i_sub  in  1  per-sample mode: 0 add, 1 subtract (data_1 - data_2).
REQ-016 i_data_1  in  IN1_W  signed operand 1.
REQ-017 i_data_2  in  IN2_W  signed operand 2.
REQ-018 i_ovf_clr  in  1  synchronous clear of o_ovf_cnt.
REQ-019 o_valid  out  1  result qualifier.
REQ-020 o_data  out  OUT_W  signed result.
REQ-021 o_ovf  out  1  per-sample overflow flag, aligned with o_data.
REQ-022 o_ovf_cnt  out  CNT_W  count of overflowed valid samples.

Function
REQ-023 Operands shall be aligned to F = max(IN1_FRAC, IN2_FRAC, OUT_FRAC) fractional bits by left shift, sign-extended to a common width one bit wider than the widest aligned integer part plus one guard bit, so add/sub is exact.
REQ-024 Negation of operand 2 shall be exact, including the most-negative code (-(-2^(IN2_W-1)) is representable).
REQ-025 Quantisation to OUT_FRAC: truncate drops LSBs; round adds 2^(F-OUT_FRAC-1) before dropping; no quantisation when F = OUT_FRAC.
REQ-026 Overflow is asserted when the quantised value is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], independent of SAT_EN.
REQ-027 With SAT_EN=1 overflowed results clamp to max positive or max negative per sign; with SAT_EN=0 upper bits are discarded.
REQ-028 Stage 1 registers the quantised result and overflow; stages 2..LATENCY form a shift delay; o_valid/o_data/o_ovf appear exactly LATENCY cycles after the i_valid cycle.
REQ-029 Pipeline shall be free-running, no backpressure; one sample accepted per cycle at full throughput.
REQ-030 When i_valid=0 the stage-1 data and overflow shall load 0, so o_data=0 and o_ovf=0 whenever o_valid=0.
REQ-031 o_ovf_cnt increments by 1 when o_valid and o_ovf are both 1; saturates at 2^CNT_W-1 (no wrap).
REQ-032 i_ovf_clr sets o_ovf_cnt to 0 next cycle and has priority over a simultaneous increment.

Reset
REQ-033 i_rst shall asynchronously clear all pipeline stages, o_valid, o_data, o_ovf and o_ovf_cnt to 0; samples in flight are discarded.
REQ-034 After i_rst deasserts, the first valid output shall appear LATENCY cycles after the first accepted i_valid.

Structure
REQ-035 A shared package shall hold the alignment-width and saturation-bound helper functions and the LATENCY legal-range constants.
REQ-036 The delay line shall be a sub-module fx_delay_line (parameters WIDTH, DEPTH) carrying {valid, ovf, data}.

Verification
REQ-037 Defaults, add 0x7FF + 0x001 -> after 2 cycles o_data=0x7FF, o_ovf=1, o_ovf_cnt=1.
REQ-038 Defaults, sub 0x000 - 0x800 -> o_data=0x7FF, o_ovf=1; with SAT_EN=0 -> o_data=0x800, o_ovf=1.
REQ-039 OUT_FRAC=4, add 0x018 + 0x000 -> RND_EN=1 gives 0x002, RND_EN=0 gives 0x001, o_ovf=0.
REQ-040 LATENCY=5, i_valid pulses on cycles 0,1,3 -> o_valid on cycles 5,6,8 only, o_data=0 elsewhere.
REQ-041 CNT_W=2, five overflowing samples -> o_ovf_cnt sticks at 3; i_ovf_clr together with a sixth overflow -> 0.
REQ-042 Assert i_rst mid-stream with 2 samples in flight -> outputs 0 immediately, no stale o_valid after release.

Source files
------------

// File: rtl/fx_addsub_pipe_pkg.sv
// Shared sizing helpers and constants for the fixed-point add/sub pipeline.
// Width arithmetic lives here so the top only declares intent.
package fx_addsub_pipe_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 16;

  function automatic int fx_max(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic int fx_align_w(
    input int w,
    input int frac,
    input int f
  );
    return w - frac + f;
  endfunction

  // Room for the widest aligned operand, exact negation, the sum carry
  // and the rounding increment.
  function automatic int fx_sum_w(
    input int a1,
    input int a2
  );
    return fx_max(a1, a2) + 3;
  endfunction

  function automatic longint fx_sat_hi(
    input int w
  );
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint fx_sat_lo(
    input int w
  );
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fx_delay_line.sv
// Resettable shift delay of DEPTH registers; DEPTH=0 is a wire.
// Carries the packed {valid, ovf, data} word of the pipeline.
module fx_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_pass
    assign o_data = i_data;
  end else begin : g_reg
    logic [WIDTH-1:0] dly_q [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        dly_q[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign o_data = dly_q[DEPTH-1];
  end

endmodule

// File: rtl/fx_addsub_pipe.sv
// Signed fixed-point add/subtract with rounding, saturation and a
// free-running LATENCY-cycle pipeline plus a sticky overflow counter.
module fx_addsub_pipe #(
  parameter int IN1_W    = 12,
  parameter int IN1_FRAC = 8,
  parameter int IN2_W    = 12,
  parameter int IN2_FRAC = 8,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 8,
  parameter int LATENCY  = 2,
  parameter int SAT_EN   = 1,
  parameter int RND_EN   = 0,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_sub,
  input  logic [IN1_W-1:0] i_data_1,
  input  logic [IN2_W-1:0] i_data_2,
  input  logic             i_ovf_clr,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  import fx_addsub_pipe_pkg::*;

  localparam int F  = fx_max(fx_max(IN1_FRAC, IN2_FRAC), OUT_FRAC);
  localparam int A1 = fx_align_w(IN1_W, IN1_FRAC, F);
  localparam int A2 = fx_align_w(IN2_W, IN2_FRAC, F);
  localparam int SW = fx_sum_w(A1, A2);
  localparam int SH = F - OUT_FRAC;
  localparam int EW = fx_max(SW, OUT_W);
  localparam int LW = OUT_W + 2;

  localparam logic [OUT_W-1:0] SAT_HI = OUT_W'(fx_sat_hi(OUT_W));
  localparam logic [OUT_W-1:0] SAT_LO = OUT_W'(fx_sat_lo(OUT_W));

  localparam logic signed [SW-1:0] RND_OFF =
    SW'(RND_EN != 0 && SH > 0) <<< (SH > 0 ? SH - 1 : 0);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
    $error("fx_addsub_pipe: LATENCY out of range");
  end

  logic signed [SW-1:0] op1;
  logic signed [SW-1:0] op2;
  logic signed [SW-1:0] sum;
  logic signed [EW-1:0] q;
  logic [EW-OUT_W:0]    q_top;
  logic                 q_ovf;

  logic                 valid_d, valid_q;
  logic                 ovf_d, ovf_q;
  logic [OUT_W-1:0]     data_d, data_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [LW-1:0]        line_out;

  always_comb begin
    op1 = SW'($signed(i_data_1));
    op1 = op1 <<< (F - IN1_FRAC);
    op2 = SW'($signed(i_data_2));
    op2 = op2 <<< (F - IN2_FRAC);
    if (i_sub) begin
      op2 = -op2;
    end
    sum = op1 + op2 + RND_OFF;
    q = EW'(sum >>> SH);
    // In range only when every bit above the sign position matches it.
    q_top = q[EW-1:OUT_W-1];
    q_ovf = !((&q_top) || !(|q_top));
  end

  always_comb begin
    valid_d = i_valid;
    ovf_d   = 1'b0;
    data_d  = '0;
    if (i_valid) begin
      ovf_d  = q_ovf;
      data_d = q[OUT_W-1:0];
      if (q_ovf && SAT_EN != 0) begin
        data_d = q[EW-1] ? SAT_LO : SAT_HI;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  fx_delay_line #(
    .WIDTH (LW),
    .DEPTH (LATENCY - 1)
  ) u_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data ({valid_q, ovf_q, data_q}),
    .o_data (line_out)
  );

  assign o_valid = line_out[LW-1];
  assign o_ovf   = line_out[LW-2];
  assign o_data  = line_out[OUT_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (i_ovf_clr) begin
      cnt_d = '0;
    end else if (o_valid && o_ovf && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_ovf_cnt = cnt_q;

endmodule
